memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter WORD_W, 13, width of address and data words.
REQ-002 Parameter TIMEOUT, 16, maximum ACCESS cycles to wait for mem_Done.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request.
REQ-006 if_addr  input  WORD_W  instruction-fetch address.
REQ-007 if_rdata  output  WORD_W  instruction-fetch read data.
REQ-008 if_done  output  1  one-cycle completion pulse for the instruction-fetch port.
REQ-009 d_req  input  1  data-port request.
REQ-010 d_we  input  1  data-port access type: 1 is write, 0 is read.
REQ-011 d_addr  input  WORD_W  data-port address.
REQ-012 d_wdata  input  WORD_W  data-port write data.
REQ-013 d_rdata  output  WORD_W  data-port read data.
REQ-014 d_done  output  1  one-cycle completion pulse for the data port.
REQ-015 mem_address, mem_dataIn  output  WORD_W  address and write data to Main_Memory.
REQ-016 mem_read, mem_write, mem_instruction  output  1  command lines to Main_Memory.
REQ-017 mem_dataOut  input  WORD_W  Main_Memory read data.
REQ-018 mem_Done  input  1  Main_Memory completion.
REQ-019 busy  output  1  high whenever state is not IDLE.
REQ-020 timeout_err  output  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-022 In IDLE, the block SHALL sample if_req and d_req; any request high SHALL be granted, and the block SHALL latch the address, wdata, we and port, then enter ACCESS.
REQ-023 When both requests are high in IDLE, the grant SHALL go to the port not granted last (round-robin); after reset the last-grant register SHALL be IF, so the first contention goes to DATA.
REQ-024 In ACCESS, mem_address SHALL equal the latched address, and mem_read or mem_write SHALL be held high for the whole state.
REQ-025 In ACCESS, mem_instruction SHALL be 1 for IF grants and 0 for DATA grants.
REQ-026 mem_dataIn SHALL carry the latched wdata during DATA writes and 0 otherwise.
REQ-027 In ACCESS, on mem_Done high the block SHALL capture mem_dataOut into the granted port's rdata (reads only) and enter RESP.
REQ-028 Each cycle spent in ACCESS without mem_Done SHALL increment a wait counter.
REQ-029 If the wait counter reaches TIMEOUT-1 without mem_Done, the block SHALL set timeout_err, load rdata with 0 for reads, and enter RESP.
REQ-030 RESP SHALL last one cycle, pulse the granted port's done, then return to IDLE.
REQ-031 rdata SHALL hold its value until that port's next completed read.
REQ-032 Latency SHALL be 2 cycles from request sampled in IDLE to done pulse when mem_Done arrives in the first ACCESS cycle, and 2+N cycles when mem_Done arrives after N additional ACCESS cycles.
REQ-033 Minimum spacing between grants SHALL be 3 cycles.
REQ-034 Requests SHALL be ignored outside IDLE, and mem_Done SHALL be ignored outside ACCESS.
REQ-035 A request dropped mid-transaction SHALL still complete and pulse done.
REQ-036 A requester SHALL hold req until its done, and SHALL drop it in the cycle after done unless it wants a new transaction.

Reset
REQ-037 On reset, the block SHALL enter IDLE and clear the wait counter.
REQ-038 On reset, all outputs SHALL be 0, including rdata, done, mem_* commands, busy and timeout_err, and last-grant SHALL be IF.
REQ-039 A reset asserted during ACCESS SHALL deassert the memory command at the next edge and SHALL produce no done pulse.

Structure
REQ-040 A shared package mem_arb_pkg SHALL hold WORD_W, the state encoding (IDLE, ACCESS, RESP) and the grant encoding (GNT_IF, GNT_D).
REQ-041 The two-way round-robin pick SHALL be the single sub-module mem_arb_rr, taking both requests and last-grant and returning the grant.

Verification
REQ-042 IF read: if_req, if_addr=0x005, mem_Done one cycle after entry to ACCESS with dataOut=0x1ABC -> if_done pulses 3 cycles after sampling, if_rdata=0x1ABC, mem_instruction=1 during ACCESS.
REQ-043 DATA write: d_we=1, d_addr=0x00A, d_wdata=0x10F0 -> mem_write=1, mem_dataIn=0x10F0, mem_instruction=0 until mem_Done, then d_done pulses; d_rdata unchanged.
REQ-044 Contention: both requests held continuously from reset -> grants alternate D, IF, D, IF, with each done pulse going to the matching port.
REQ-045 Timeout: d_req read with mem_Done never asserted -> after TIMEOUT ACCESS cycles, timeout_err=1 (sticky), d_done pulses, d_rdata=0.
REQ-046 Reset mid-ACCESS: reset asserted on the 2nd ACCESS cycle -> next cycle all outputs are 0, state is IDLE, no done pulse.
REQ-047 Dropped request: if_req deasserted during ACCESS -> transaction completes, if_done still pulses, no re-grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: word width, FSM states and grant encoding.
package mem_arb_pkg;

  localparam int unsigned WORD_W = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: on contention the port not granted last wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  gnt_t last_gnt,
  output gnt_t grant
);

  always_comb begin
    grant = GNT_IF;
    if (if_req && d_req) begin
      if (last_gnt == GNT_IF) grant = GNT_D;
      else                    grant = GNT_IF;
    end else if (d_req) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one Main_Memory interface,
// one transaction at a time, with a bounded wait for mem_Done.
module memory_arbiter #(
  parameter int unsigned WORD_W  = mem_arb_pkg::WORD_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_done,
  output logic [WORD_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_dataIn,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_instruction,
  input  logic [WORD_W-1:0] mem_dataOut,
  input  logic              mem_Done,
  output logic              busy,
  output logic              timeout_err
);

  import mem_arb_pkg::*;

  localparam int unsigned     CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  state_t            state, state_nxt;
  gnt_t              last_gnt, gnt_sel, port;
  logic              we;
  logic [WORD_W-1:0] addr, wdata;
  logic [CW-1:0]     wait_cnt;
  logic              expired;

  mem_arb_rr u_rr (
    .if_req  (if_req),
    .d_req   (d_req),
    .last_gnt(last_gnt),
    .grant   (gnt_sel)
  );

  assign expired = (wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_gnt    <= GNT_IF;
      port        <= GNT_IF;
      we          <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      wait_cnt    <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            port     <= gnt_sel;
            last_gnt <= gnt_sel;
            wait_cnt <= '0;
            if (gnt_sel == GNT_D) begin
              addr  <= d_addr;
              wdata <= d_wdata;
              we    <= d_we;
            end else begin
              addr  <= if_addr;
              wdata <= '0;
              we    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          // A timed-out read returns zero to the port instead of stale memory data.
          if (mem_Done || expired) begin
            if (!mem_Done) timeout_err <= 1'b1;
            if (!we) begin
              if (port == GNT_IF) if_rdata <= mem_Done ? mem_dataOut : '0;
              else                d_rdata  <= mem_Done ? mem_dataOut : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt       = state;
    busy            = (state != IDLE);
    mem_address     = '0;
    mem_dataIn      = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_instruction = 1'b0;
    if_done         = 1'b0;
    d_done          = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_address     = addr;
        mem_read        = !we;
        mem_write       = we;
        mem_instruction = (port == GNT_IF);
        if (we) mem_dataIn = wdata;
        if (mem_Done || expired) state_nxt = RESP;
      end
      RESP: begin
        if_done   = (port == GNT_IF);
        d_done    = (port == GNT_D);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter; completions are matched against a queue of expected results.
module tb_memory_arbiter;

  import mem_arb_pkg::*;

  localparam int unsigned W  = 13;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_req, d_req, d_we, mem_Done;
  logic [W-1:0] if_addr, d_addr, d_wdata, mem_dataOut;
  logic [W-1:0] if_rdata, d_rdata, mem_address, mem_dataIn;
  logic         if_done, d_done, mem_read, mem_write, mem_instruction, busy, timeout_err;

  logic         auto_resp;
  logic [W-1:0] data_drv;

  typedef struct {
    gnt_t         port;
    logic [W-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   dones    = 0;

  memory_arbiter #(.WORD_W(W), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_rdata       (if_rdata),
    .if_done        (if_done),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_done         (d_done),
    .mem_address    (mem_address),
    .mem_dataIn     (mem_dataIn),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_instruction(mem_instruction),
    .mem_dataOut    (mem_dataOut),
    .mem_Done       (mem_Done),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Memory model: either a directed value or a fixed function of the address.
  always_comb mem_dataOut = auto_resp ? (mem_address ^ 13'h1555) : data_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},        busy,            0);
    chk({tag, "_mem_read"},    mem_read,        0);
    chk({tag, "_mem_write"},   mem_write,       0);
    chk({tag, "_mem_instr"},   mem_instruction, 0);
    chk({tag, "_mem_address"}, mem_address,     0);
    chk({tag, "_mem_dataIn"},  mem_dataIn,      0);
    chk({tag, "_if_done"},     if_done,         0);
    chk({tag, "_d_done"},      d_done,          0);
    chk({tag, "_if_rdata"},    if_rdata,        0);
    chk({tag, "_d_rdata"},     d_rdata,         0);
    chk({tag, "_timeout_err"}, timeout_err,     0);
  endtask

  // Completion monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && (if_done || d_done)) begin
      dones++;
      chk("done_onehot", {31'b0, if_done & d_done}, 0);
      chk("sb_nonempty", {31'b0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("done_port_is_d", {31'b0, d_done}, {31'b0, mon_e.port == GNT_D});
        chk("done_rdata", (mon_e.port == GNT_IF) ? if_rdata : d_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    int n;
    int dones_snap;
    gnt_t g_exp;

    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_Done = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; auto_resp = 1'b0; data_drv = '0;
    step(); step();
    chk_all_zero("rst");
    reset = 1'b0;

    // IF read, mem_Done one cycle after entering ACCESS
    if_req = 1'b1; if_addr = 13'h005;
    sb.push_back('{port: GNT_IF, rdata: 13'h1ABC});
    step();
    chk("if_a1_busy",  busy, 1);
    chk("if_a1_read",  mem_read, 1);
    chk("if_a1_write", mem_write, 0);
    chk("if_a1_instr", mem_instruction, 1);
    chk("if_a1_addr",  mem_address, 13'h005);
    chk("if_a1_din",   mem_dataIn, 0);
    step();
    chk("if_a2_instr", mem_instruction, 1);
    chk("if_a2_done",  if_done, 0);
    mem_Done = 1'b1; data_drv = 13'h1ABC;
    step();
    chk("if_r_done",  if_done, 1);
    chk("if_r_rdata", if_rdata, 13'h1ABC);
    chk("if_r_read",  mem_read, 0);
    if_req = 1'b0; mem_Done = 1'b0;
    step();
    chk("if_i_done", if_done, 0);
    chk("if_i_busy", busy, 0);
    chk("if_i_hold", if_rdata, 13'h1ABC);

    // DATA write
    d_req = 1'b1; d_we = 1'b1; d_addr = 13'h00A; d_wdata = 13'h10F0;
    sb.push_back('{port: GNT_D, rdata: 13'h0000});
    step();
    chk("wr_write", mem_write, 1);
    chk("wr_read",  mem_read, 0);
    chk("wr_din",   mem_dataIn, 13'h10F0);
    chk("wr_instr", mem_instruction, 0);
    chk("wr_addr",  mem_address, 13'h00A);
    mem_Done = 1'b1; data_drv = 13'h1234;
    step();
    chk("wr_done",   d_done, 1);
    chk("wr_rdata",  d_rdata, 0);
    chk("wr_ifhold", if_rdata, 13'h1ABC);
    d_req = 1'b0; d_we = 1'b0; mem_Done = 1'b0;
    step();
    chk("wr_i_din",   mem_dataIn, 0);
    chk("wr_i_write", mem_write, 0);

    // mem_Done on the last permitted ACCESS cycle completes normally
    d_req = 1'b1; d_addr = 13'h00D; data_drv = 13'h0777;
    sb.push_back('{port: GNT_D, rdata: 13'h0777});
    step();
    for (int i = 1; i < int'(TO); i++) begin
      chk("bnd_access", mem_read, 1);
      step();
    end
    chk("bnd_last_access", mem_read, 1);
    chk("bnd_no_to_yet", timeout_err, 0);
    mem_Done = 1'b1;
    step();
    chk("bnd_done",  d_done, 1);
    chk("bnd_to",    timeout_err, 0);
    chk("bnd_rdata", d_rdata, 13'h0777);
    d_req = 1'b0; mem_Done = 1'b0;
    step();

    // Timeout: mem_Done never arrives
    d_req = 1'b1; d_addr = 13'h00D;
    sb.push_back('{port: GNT_D, rdata: 13'h0000});
    step();
    n = 0;
    while (mem_read && n < 40) begin
      n++;
      step();
    end
    chk("to_cycles", n, TO);
    chk("to_err",    timeout_err, 1);
    chk("to_done",   d_done, 1);
    chk("to_rdata",  d_rdata, 0);
    d_req = 1'b0;
    step();
    chk("to_sticky", timeout_err, 1);
    chk("to_i_done", d_done, 0);

    // Contention from reset: D, IF, D, IF
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 13'h00C; d_addr = 13'h00B; auto_resp = 1'b1; mem_Done = 1'b1;
    for (int g = 0; g < 4; g++)
      sb.push_back('{port: (g % 2 == 0) ? GNT_D : GNT_IF,
                     rdata: (g % 2 == 0) ? (13'h00B ^ 13'h1555) : (13'h00C ^ 13'h1555)});
    step();
    chk("ct_rst_err", timeout_err, 0);
    chk("ct_rst_busy", busy, 0);
    reset = 1'b0;
    for (int g = 0; g < 4; g++) begin
      g_exp = (g % 2 == 0) ? GNT_D : GNT_IF;
      step();
      chk("ct_instr", mem_instruction, {31'b0, g_exp == GNT_IF});
      chk("ct_addr",  mem_address, (g_exp == GNT_IF) ? 13'h00C : 13'h00B);
      step();
      chk("ct_if_done", if_done, {31'b0, g_exp == GNT_IF});
      chk("ct_d_done",  d_done,  {31'b0, g_exp == GNT_D});
      if (g == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      step();
      chk("ct_idle", busy, 0);
    end

    // Reset on the second ACCESS cycle aborts without a done pulse
    auto_resp = 1'b0; mem_Done = 1'b0; if_req = 1'b1; if_addr = 13'h00F;
    step();
    step();
    chk("ra_a2_read", mem_read, 1);
    reset = 1'b1;
    step();
    chk_all_zero("ra");
    reset = 1'b0; if_req = 1'b0;
    dones_snap = dones;
    step(); step(); step();
    chk("ra_no_done", dones, dones_snap);
    chk("ra_idle", busy, 0);

    // IF request dropped mid-ACCESS still completes, with no re-grant
    auto_resp = 1'b1; if_req = 1'b1; if_addr = 13'h00E;
    sb.push_back('{port: GNT_IF, rdata: 13'h00E ^ 13'h1555});
    step();
    if_req = 1'b0;
    step();
    mem_Done = 1'b1;
    step();
    chk("dr_done", if_done, 1);
    mem_Done = 1'b0;
    step(); step(); step();
    chk("dr_no_regrant", busy, 0);
    chk("dr_no_read", mem_read, 0);

    chk("sb_empty", sb.size(), 0);
    chk("done_count", dones, 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
